warp_issue_scheduler: RTL and testbench

Parametrised single-port warp issue scheduler for the SM front end, sitting between the per-warp scoreboard and the decode/issue pipeline. It selects one eligible warp per cycle using a runtime-selectable policy: loose round-robin (LRR) or greedy-then-oldest (GTO). GTO uses per-warp age counters. Grants use a valid/ready handshake and sustain back-to-back issue at one warp per cycle.

---
 rtl/warp_issue_scheduler.sv | 127 ++++++++++++
 tb/tb_warp_issue_scheduler.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/warp_issue_scheduler.sv
// Warp issue scheduler: picks one eligible warp per cycle (LRR or GTO)
// and offers it to decode through a registered valid/ready handshake.
module warp_issue_scheduler #(
  parameter int W    = 32,
  parameter int WIDX = $clog2(W),
  parameter int AGEW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [W-1:0]    ready_mask,
  input  logic [W-1:0]    active_mask,
  input  logic            launch_valid,
  input  logic [WIDX-1:0] launch_id,
  input  logic            mode,
  output logic            issue_valid,
  output logic [WIDX-1:0] issue_warp_id,
  input  logic            issue_ready
);

  typedef enum logic {IDLE, OFFER} state_t;

  localparam logic [WIDX:0]   WL      = (WIDX+1)'(W);
  localparam logic [AGEW-1:0] AGE_MAX = '1;

  state_t          state, state_nxt;
  logic [W-1:0]    cand, rot;
  logic            any_cand, accept, load;
  logic [WIDX-1:0] rr_ptr, greedy_id;
  logic            greedy_vld;
  logic [WIDX:0]   nx_ptr, lrr_j, lrr_sum;
  logic [WIDX-1:0] acc_next, lrr_start, lrr_id;
  logic            g_vld_eff, g_found;
  logic [WIDX-1:0] g_id_eff, g_best, gto_id, sel_id;
  logic [AGEW-1:0] g_age;
  logic [AGEW-1:0] age [W];

  assign cand     = ready_mask & active_mask;
  assign any_cand = |cand;
  assign accept   = issue_valid & issue_ready;
  assign load     = any_cand & ((state == IDLE) | issue_ready);

  assign nx_ptr   = {1'b0, issue_warp_id} + (WIDX+1)'(1);
  assign acc_next = (nx_ptr == WL) ? '0 : WIDX'(nx_ptr);

  // A selection made on an accept edge must see the post-accept policy state
  assign lrr_start = accept ? acc_next : rr_ptr;
  assign g_vld_eff = accept | greedy_vld;
  assign g_id_eff  = accept ? issue_warp_id : greedy_id;

  assign rot = W'({cand, cand} >> lrr_start);

  always_comb begin
    lrr_j = '0;
    for (int i = W-1; i >= 0; i--)
      if (rot[i]) lrr_j = (WIDX+1)'(i);
  end

  assign lrr_sum = {1'b0, lrr_start} + lrr_j;
  assign lrr_id  = WIDX'((lrr_sum >= WL) ? lrr_sum - WL : lrr_sum);

  always_comb begin
    g_found = 1'b0;
    g_age   = '0;
    g_best  = '0;
    for (int i = 0; i < W; i++) begin
      if (cand[i] && (!g_found || age[i] > g_age)) begin
        g_found = 1'b1;
        g_age   = age[i];
        g_best  = WIDX'(i);
      end
    end
  end

  assign gto_id = (g_vld_eff && cand[g_id_eff]) ? g_id_eff : g_best;
  assign sel_id = mode ? gto_id : lrr_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == IDLE):  if (any_cand) state_nxt = OFFER;
      (state == OFFER): if (issue_ready && !any_cand) state_nxt = IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  always_comb begin
    issue_valid = (state == OFFER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_warp_id <= '0;
      rr_ptr        <= '0;
      greedy_id     <= '0;
      greedy_vld    <= 1'b0;
    end else begin
      if (load) issue_warp_id <= sel_id;
      if (accept) begin
        rr_ptr     <= acc_next;
        greedy_id  <= issue_warp_id;
        greedy_vld <= 1'b1;
      end else if (!active_mask[greedy_id]) begin
        greedy_vld <= 1'b0;
      end
    end
  end

  // Launch ids >= W never match any slot, so they are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < W; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < W; i++) begin
        if (!active_mask[i] || (launch_valid && launch_id == WIDX'(i)))
          age[i] <= '0;
        else if (age[i] != AGE_MAX)
          age[i] <= age[i] + AGEW'(1);
      end
    end
  end

endmodule

// File: tb/tb_warp_issue_scheduler.sv
// Bench for warp_issue_scheduler: vector table plus directed sequences
// on a 4-warp (AGEW=3) instance and a 6-warp instance.
module tb_warp_issue_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] ready, active;
  logic       lv, mode, ir;
  logic [1:0] lid;
  logic       valid;
  logic [1:0] wid;

  logic [5:0] ready6, active6;
  logic       ir6;
  logic       valid6;
  logic [2:0] wid6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  warp_issue_scheduler #(.W(4), .AGEW(3)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .ready_mask(ready), .active_mask(active),
    .launch_valid(lv), .launch_id(lid), .mode(mode),
    .issue_valid(valid), .issue_warp_id(wid),
    .issue_ready(ir)
  );

  warp_issue_scheduler #(.W(6)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .ready_mask(ready6), .active_mask(active6),
    .launch_valid(1'b0), .launch_id(3'd0), .mode(1'b0),
    .issue_valid(valid6), .issue_warp_id(wid6),
    .issue_ready(ir6)
  );

  typedef struct {
    logic [3:0] ready;
    logic [3:0] active;
    logic       lv;
    logic [1:0] lid;
    logic       mode;
    logic       ir;
    logic       ev;
    logic [1:0] eid;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(string nm, logic ev, int eid);
    chk({nm, "_valid"}, int'(valid), int'(ev));
    if (ev) chk({nm, "_id"}, int'(wid), eid);
  endtask

  task automatic zero_inputs();
    ready = '0; active = '0; lv = 0; lid = '0;
    mode = 0; ir = 0;
    ready6 = '0; active6 = '0; ir6 = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    zero_inputs();
    step();
    step();
    rst_n = 1;
  endtask

  initial begin
    // ready active lv lid mode ir | ev eid
    vecs.push_back('{4'b0000, 4'b1111, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{4'b1111, 4'b1111, 0, 0, 0, 1, 1, 0});
    vecs.push_back('{4'b1111, 4'b1111, 0, 0, 0, 1, 1, 1});
    vecs.push_back('{4'b1111, 4'b1111, 0, 0, 0, 1, 1, 2});
    vecs.push_back('{4'b1111, 4'b1111, 0, 0, 0, 1, 1, 3});
    vecs.push_back('{4'b1111, 4'b1111, 0, 0, 0, 1, 1, 0});
    vecs.push_back('{4'b0000, 4'b1111, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{4'b1001, 4'b1111, 0, 0, 0, 0, 1, 3});
    vecs.push_back('{4'b1001, 4'b1111, 0, 0, 0, 0, 1, 3});
    vecs.push_back('{4'b0001, 4'b1111, 0, 0, 0, 1, 1, 0});
    vecs.push_back('{4'b0000, 4'b1111, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{4'b0110, 4'b1111, 0, 0, 1, 1, 1, 1});
    vecs.push_back('{4'b0110, 4'b1111, 0, 0, 1, 1, 1, 1});
    vecs.push_back('{4'b0100, 4'b1111, 0, 0, 1, 1, 1, 2});
    vecs.push_back('{4'b0000, 4'b1111, 0, 0, 1, 1, 0, 0});

    rst_n = 0;
    zero_inputs();
    #2;
    chk("rst_valid", int'(valid), 0);
    chk("rst_id", int'(wid), 0);
    do_reset();

    foreach (vecs[i]) begin
      ready  = vecs[i].ready;
      active = vecs[i].active;
      lv     = vecs[i].lv;
      lid    = vecs[i].lid;
      mode   = vecs[i].mode;
      ir     = vecs[i].ir;
      step();
      expect_out($sformatf("vec%0d", i), vecs[i].ev, int'(vecs[i].eid));
    end

    // Backpressure: offer held while its ready bit drops
    do_reset();
    active = 4'b1111; ready = 4'b0100;
    step();
    expect_out("bp_offer", 1, 2);
    ready = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      step();
      expect_out($sformatf("bp_hold%0d", k), 1, 2);
    end
    ir = 1;
    step();
    expect_out("bp_idle", 0, 0);

    // GTO: launches 1, 3, 0 three cycles apart
    do_reset();
    mode = 1; ir = 1;
    active = 4'b0010; lv = 1; lid = 2'd1;
    step();
    lv = 0;
    chk("age1_launch", int'(dut4.age[1]), 0);
    expect_out("gto_none", 0, 0);
    step(); step();
    active = 4'b1010; lv = 1; lid = 2'd3;
    step();
    lv = 0;
    chk("age1_run", int'(dut4.age[1]), 3);
    chk("age3_launch", int'(dut4.age[3]), 0);
    step(); step();
    active = 4'b1011; lv = 1; lid = 2'd0;
    step();
    lv = 0;
    chk("age0_launch", int'(dut4.age[0]), 0);
    step(); step();
    ready = 4'b1011;
    step();
    expect_out("gto_oldest", 1, 1);
    step();
    expect_out("gto_greedy1", 1, 1);
    step();
    expect_out("gto_greedy2", 1, 1);
    ready = 4'b1001;
    step();
    expect_out("gto_next_old", 1, 3);
    ir = 0;
    step();
    expect_out("gto_hold", 1, 3);
    ready = 4'b0011; ir = 1;
    step();
    expect_out("gto_tie_low", 1, 0);
    chk("age1_sat", int'(dut4.age[1]), 7);
    active = 4'b1001; ready = 4'b0000;
    step();
    expect_out("gto_idle", 0, 0);
    chk("age1_clear", int'(dut4.age[1]), 0);
    chk("age0_sat", int'(dut4.age[0]), 7);

    // Async reset in the middle of an offer
    do_reset();
    active = 4'b1111; ready = 4'b1111; ir = 1;
    step();
    expect_out("ar_0", 1, 0);
    step();
    expect_out("ar_1", 1, 1);
    step();
    expect_out("ar_2", 1, 2);
    #2;
    rst_n = 0;
    ready = 4'b0000;
    #1;
    chk("ar_async_valid", int'(valid), 0);
    chk("ar_async_id", int'(wid), 0);
    step();
    rst_n = 1;
    step();
    expect_out("ar_no_replay", 0, 0);
    ready = 4'b1010;
    step();
    expect_out("ar_from_ptr0", 1, 1);

    // Non-power-of-two wrap
    do_reset();
    active6 = 6'b111111; ready6 = 6'b100001; ir6 = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("w6_valid%0d", k), int'(valid6), 1);
      chk($sformatf("w6_id%0d", k), int'(wid6), (k % 2 == 0) ? 0 : 5);
      chk($sformatf("w6_ptr%0d", k), int'(dut6.rr_ptr), k % 2);
    end
    ready6 = '0;
    step();
    chk("w6_idle", int'(valid6), 0);
    chk("w6_ptr_wrap", int'(dut6.rr_ptr), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
